// File: rtl/uart_init_ctrl_pkg.sv
// Shared state encoding, register map and bus beat type for the UART init sequencer.
// Package name uart_pkg; imported by the controller top.
package uart_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_LCR_DLAB,
        WR_DLL,
        WR_DLM,
        WR_LCR,
        WR_FCR,
        GAP_WAIT,
        DONE,
        RD_DLL,
        RD_DLM,
        RD_LCR,
        CHK
    } state_t;

    localparam logic [2:0] RBR_THR_DLL = 3'd0;
    localparam logic [2:0] IER_DLM     = 3'd1;
    localparam logic [2:0] IIR_FCR     = 3'd2;
    localparam logic [2:0] LCR         = 3'd3;

    localparam int DLAB_BIT = 7;

    // One register-bus beat as presented to the UART register block.
    typedef struct packed {
        logic       wr;
        logic       rd;
        logic [2:0] addr;
        logic [7:0] data;
    } bus_t;

endpackage

// File: rtl/uart_init_ctrl_if.sv
// Register-bus link between the init sequencer (master) and a UART register block (slave).
interface uart_init_ctrl_if;

    logic       wr_o;
    logic       rd_o;
    logic [2:0] addr_o;
    logic [7:0] dout_o;
    logic [7:0] din_i;

    modport master (output wr_o, rd_o, addr_o, dout_o, input din_i);
    modport slave  (input  wr_o, rd_o, addr_o, dout_o, output din_i);

endinterface

// File: rtl/uart_init_ctrl.sv
// UART init sequencer: programs divisor latch, LCR and FCR with GAP idle cycles between accesses.
// Define UART_INIT_READBACK_EN to read back DLL, DLM and LCR and flag mismatches on err_o.
module uart_init_ctrl
    import uart_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [15:0]      divisor_i,
    input  logic [7:0]       lcr_i,
    input  logic [7:0]       fcr_i,
    uart_init_ctrl_if.master bus,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam logic [7:0] DLAB_MASK = 8'(1 << DLAB_BIT);
    localparam logic [3:0] GAP_M1    = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [3:0] GAP_M2    = (GAP > 1) ? 4'(GAP - 2) : 4'd0;

    state_t      r_state;
    state_t      r_next;
    logic [3:0]  r_gap_cnt;
    logic [15:0] r_div;
    logic [7:0]  r_lcr;
    logic [7:0]  r_fcr;
    bus_t        r_bus;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
`ifdef UART_INIT_READBACK_EN
    logic [7:0]  r_exp;
`endif

    state_t      w_seq_next;
    bus_t        w_bus_seq;
    bus_t        w_bus_nxt;
    bus_t        w_bus_first;
    logic [7:0]  w_lcr_in;

    function automatic bus_t bus_for(input state_t s, input logic [15:0] div,
                                     input logic [7:0] lcr, input logic [7:0] fcr);
        bus_t b;
        b = '0;
        case (s)
            WR_LCR_DLAB: begin b.wr = 1'b1; b.addr = LCR;         b.data = lcr | DLAB_MASK;  end
            WR_DLL:      begin b.wr = 1'b1; b.addr = RBR_THR_DLL; b.data = div[7:0];         end
            WR_DLM:      begin b.wr = 1'b1; b.addr = IER_DLM;     b.data = div[15:8];        end
            WR_LCR:      begin b.wr = 1'b1; b.addr = LCR;         b.data = lcr & ~DLAB_MASK; end
            WR_FCR:      begin b.wr = 1'b1; b.addr = IIR_FCR;     b.data = fcr;              end
`ifdef UART_INIT_READBACK_EN
            RD_DLL:      begin b.rd = 1'b1; b.addr = RBR_THR_DLL; end
            RD_DLM:      begin b.rd = 1'b1; b.addr = IER_DLM;     end
            RD_LCR:      begin b.rd = 1'b1; b.addr = LCR;         end
`endif
            default:     b = '0;
        endcase
        return b;
    endfunction

    // Access order; every other state falls through to DONE.
    function automatic state_t seq_next(input state_t s);
        case (s)
            WR_LCR_DLAB: return WR_DLL;
            WR_DLL:      return WR_DLM;
`ifdef UART_INIT_READBACK_EN
            WR_DLM:      return RD_DLL;
            RD_DLL:      return RD_DLM;
            RD_DLM:      return WR_LCR;
            WR_LCR:      return RD_LCR;
            RD_LCR:      return WR_FCR;
`else
            WR_DLM:      return WR_LCR;
            WR_LCR:      return WR_FCR;
`endif
            default:     return DONE;
        endcase
    endfunction

`ifdef UART_INIT_READBACK_EN
    function automatic logic [7:0] rb_exp(input state_t s, input logic [15:0] div,
                                          input logic [7:0] lcr);
        case (s)
            RD_DLL:  return div[7:0];
            RD_DLM:  return div[15:8];
            default: return lcr;
        endcase
    endfunction
`endif

    assign w_lcr_in    = lcr_i & ~DLAB_MASK;
    assign w_seq_next  = seq_next(r_state);
    assign w_bus_seq   = bus_for(w_seq_next, r_div, r_lcr, r_fcr);
    assign w_bus_nxt   = bus_for(r_next, r_div, r_lcr, r_fcr);
    assign w_bus_first = bus_for(WR_LCR_DLAB, divisor_i, w_lcr_in, fcr_i);

    // Bus beats are registered on entry to each access state, so outputs line up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_next    <= IDLE;
            r_gap_cnt <= '0;
            r_div     <= '0;
            r_lcr     <= '0;
            r_fcr     <= '0;
            r_bus     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef UART_INIT_READBACK_EN
            r_exp     <= '0;
`endif
        end else begin
            r_bus  <= '0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_div  <= divisor_i;
                        r_lcr  <= w_lcr_in;
                        r_fcr  <= fcr_i;
                        r_busy <= 1'b1;
                        r_err  <= (divisor_i == 16'd0);
                        if (divisor_i == 16'd0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= WR_LCR_DLAB;
                            r_bus   <= w_bus_first;
                        end
                    end
                end
                GAP_WAIT: begin
                    if (r_gap_cnt == 4'd0) begin
                        r_state <= r_next;
                        r_bus   <= w_bus_nxt;
                        r_done  <= (r_next == DONE);
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
`ifdef UART_INIT_READBACK_EN
                RD_DLL, RD_DLM, RD_LCR: begin
                    r_state <= CHK;
                    r_next  <= w_seq_next;
                    r_exp   <= rb_exp(r_state, r_div, r_lcr);
                end
                // CHK doubles as the first idle cycle after a read.
                CHK: begin
                    if (bus.din_i != r_exp) r_err <= 1'b1;
                    if (GAP <= 1) begin
                        r_state <= r_next;
                        r_bus   <= w_bus_nxt;
                        r_done  <= (r_next == DONE);
                    end else begin
                        r_state   <= GAP_WAIT;
                        r_gap_cnt <= GAP_M2;
                    end
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    if (GAP == 0) begin
                        r_state <= w_seq_next;
                        r_bus   <= w_bus_seq;
                        r_done  <= (w_seq_next == DONE);
                    end else begin
                        r_state   <= GAP_WAIT;
                        r_gap_cnt <= GAP_M1;
                        r_next    <= w_seq_next;
                    end
                end
            endcase
        end
    end

    // rd is only ever set by the readback states, so it stays 0 in the default build.
    assign bus.wr_o   = r_bus.wr;
    assign bus.rd_o   = r_bus.rd;
    assign bus.addr_o = r_bus.addr;
    assign bus.dout_o = r_bus.data;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;

endmodule

// File: tb/tb_uart_init_ctrl.sv
// Randomized bench for uart_init_ctrl: three instances (GAP 0, 1, 3) checked cycle by cycle
// against a trace built from the access list, plus a register-block model answering reads.
module tb_uart_init_ctrl;

    typedef logic [15:0] trace_t [$];

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [15:0] divisor_i;
    logic [7:0]  lcr_i;
    logic [7:0]  fcr_i;
    logic        busy0, done0, err0;
    logic        busy1, done1, err1;
    logic        busy3, done3, err3;

    int n_vec = 0;
    int n_err = 0;
    int gaps [3] = '{0, 1, 3};
    bit bad_dll;
    logic [7:0] rf [3][8];

    uart_init_ctrl_if if0 ();
    uart_init_ctrl_if if1 ();
    uart_init_ctrl_if if3 ();

    uart_init_ctrl #(.GAP(0)) dut0 (.clk(clk), .rst(rst), .start_i(start_i), .divisor_i(divisor_i),
        .lcr_i(lcr_i), .fcr_i(fcr_i), .bus(if0), .busy_o(busy0), .done_o(done0), .err_o(err0));
    uart_init_ctrl #(.GAP(1)) dut1 (.clk(clk), .rst(rst), .start_i(start_i), .divisor_i(divisor_i),
        .lcr_i(lcr_i), .fcr_i(fcr_i), .bus(if1), .busy_o(busy1), .done_o(done1), .err_o(err1));
    uart_init_ctrl #(.GAP(3)) dut3 (.clk(clk), .rst(rst), .start_i(start_i), .divisor_i(divisor_i),
        .lcr_i(lcr_i), .fcr_i(fcr_i), .bus(if3), .busy_o(busy3), .done_o(done3), .err_o(err3));

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_val(input int i, input logic [2:0] a);
        return (bad_dll && a == 3'd0) ? 8'h09 : rf[i][a];
    endfunction

    // Register-block model: writes land in rf, read data appears the cycle after rd_o.
    always @(posedge clk) begin
        if (if0.wr_o) rf[0][if0.addr_o] <= if0.dout_o;
        if (if1.wr_o) rf[1][if1.addr_o] <= if1.dout_o;
        if (if3.wr_o) rf[2][if3.addr_o] <= if3.dout_o;
        if0.din_i <= if0.rd_o ? rd_val(0, if0.addr_o) : 8'h00;
        if1.din_i <= if1.rd_o ? rd_val(1, if1.addr_o) : 8'h00;
        if3.din_i <= if3.rd_o ? rd_val(2, if3.addr_o) : 8'h00;
    end

    function automatic logic [15:0] pk(input bit wr, input bit rd, input logic [2:0] a,
                                       input logic [7:0] d, input bit busy, input bit done,
                                       input bit err);
        return {wr, rd, a, d, busy, done, err};
    endfunction

    function automatic logic [15:0] obs(input int i);
        case (i)
            0:       return {if0.wr_o, if0.rd_o, if0.addr_o, if0.dout_o, busy0, done0, err0};
            1:       return {if1.wr_o, if1.rd_o, if1.addr_o, if1.dout_o, busy1, done1, err1};
            default: return {if3.wr_o, if3.rd_o, if3.addr_o, if3.dout_o, busy3, done3, err3};
        endcase
    endfunction

    // Expected per-cycle outputs, starting with the cycle right after start acceptance.
    function automatic trace_t build_trace(input int gap, input logic [15:0] d, input logic [7:0] l,
                                           input logic [7:0] f, input bit bad);
        trace_t t;
        logic [11:0] acc [$];
        logic [7:0] lc;
        bit err;
        err = 1'b0;
        lc = l & 8'h7F;
        if (d == 16'd0) begin
            t.push_back(pk(0, 0, 3'd0, 8'h00, 1, 1, 1));
            return t;
        end
        acc.push_back({1'b0, 3'd3, lc | 8'h80});
        acc.push_back({1'b0, 3'd0, d[7:0]});
        acc.push_back({1'b0, 3'd1, d[15:8]});
`ifdef UART_INIT_READBACK_EN
        acc.push_back({1'b1, 3'd0, d[7:0]});
        acc.push_back({1'b1, 3'd1, d[15:8]});
`endif
        acc.push_back({1'b0, 3'd3, lc});
`ifdef UART_INIT_READBACK_EN
        acc.push_back({1'b1, 3'd3, lc});
`endif
        acc.push_back({1'b0, 3'd2, f});
        foreach (acc[i]) begin
            bit rd;
            logic [2:0] a;
            logic [7:0] v;
            int idle;
            rd = acc[i][11];
            a = acc[i][10:8];
            v = acc[i][7:0];
            idle = (rd && gap == 0) ? 1 : gap;
            t.push_back(pk(!rd, rd, a, rd ? 8'h00 : v, 1, 0, err));
            for (int j = 0; j < idle; j++) begin
                t.push_back(pk(0, 0, 3'd0, 8'h00, 1, 0, err));
                if (j == 0 && rd && bad && a == 3'd0 && v != 8'h09) err = 1'b1;
            end
        end
        t.push_back(pk(0, 0, 3'd0, 8'h00, 1, 1, err));
        return t;
    endfunction

    task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h ({wr,rd,addr,dout,busy,done,err})", tag, got, exp);
        end
    endtask

    task automatic run_seq(input logic [15:0] d, input logic [7:0] l, input logic [7:0] f,
                           input int dist_k, input int rst_k, input bit bad);
        trace_t tr [3];
        int n;
        n = 0;
        bad_dll = bad;
        for (int i = 0; i < 3; i++) begin
            tr[i] = build_trace(gaps[i], d, l, f, bad);
            if (tr[i].size() > n) n = tr[i].size();
        end
        divisor_i = d;
        lcr_i = l;
        fcr_i = f;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 1; k <= n + 2; k++) begin
            if (k == rst_k) begin
                rst = 1'b1;
                #1;
                for (int i = 0; i < 3; i++)
                    check_vec($sformatf("rst_async g%0d", gaps[i]), obs(i), 16'h0000);
                @(posedge clk); #1;
                rst = 1'b0;
                repeat (4) begin
                    @(posedge clk); #1;
                    for (int i = 0; i < 3; i++)
                        check_vec($sformatf("post_rst g%0d", gaps[i]), obs(i), 16'h0000);
                end
                return;
            end
            for (int i = 0; i < 3; i++) begin
                logic [15:0] e;
                e = (k <= tr[i].size()) ? tr[i][k-1] : (tr[i][tr[i].size()-1] & ~16'h0006);
                check_vec($sformatf("g%0d d=%h cyc%0d", gaps[i], d, k), obs(i), e);
            end
            if (k == dist_k) begin
                start_i = 1'b1;
                divisor_i = 16'hFFFF;
                lcr_i = 8'($urandom);
                fcr_i = 8'($urandom);
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int dk;
        int rk;
        rst = 1'b1;
        start_i = 1'b0;
        divisor_i = '0;
        lcr_i = '0;
        fcr_i = '0;
        bad_dll = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            check_vec($sformatf("reset g%0d", gaps[i]), obs(i), 16'h0000);
        rst = 1'b0;
        @(posedge clk); #1;

        run_seq(16'h0108, 8'h03, 8'hC7, 0, 0, 1'b0);
        run_seq(16'h0000, 8'h5A, 8'h01, 0, 0, 1'b0);
        run_seq(16'h0108, 8'h03, 8'hC7, 3, 0, 1'b0);
        run_seq(16'h0108, 8'h03, 8'hC7, 0, 5, 1'b0);
        run_seq(16'h1234, 8'h9B, 8'h07, 0, 0, 1'b1);

        repeat (24) begin
            d = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 65535));
            dk = (d != 16'd0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
            rk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 8)) : 0;
            run_seq(d, 8'($urandom), 8'($urandom), dk, rk, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
